// File: rtl/mem_multiport_init.sv
`default_nettype none
// ============================================================================
// Module      : mem_multiport_init
// Description : Multi-port word memory with a hardware clear sweep and
//               highest-port-wins same-address write arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_multiport_init #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 9,
    parameter int                 DEPTH    = 512,
    parameter int                 N_RD     = 2,
    parameter int                 N_WR     = 4,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_WR-1:0]          write,
    input  logic [N_WR*ADDR_W-1:0]   address_write,
    input  logic [N_WR*DATA_W-1:0]   data_write,
    input  logic [N_RD*ADDR_W-1:0]   address_read,
    output logic [N_RD*DATA_W-1:0]   readed,
    output logic                     init_busy,
    output logic                     collision,
    output logic                     oob
);

    localparam int                 c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_IDX_W-1:0]  r_init_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_collision;
    logic                r_oob;

    logic [ADDR_W-1:0]   w_waddr    [N_WR];
    logic [DATA_W-1:0]   w_wdata    [N_WR];
    logic [N_WR-1:0]     w_win_range;
    logic [N_WR-1:0]     w_commit;
    logic                w_coll;
    logic                w_oob_wr;
    logic [ADDR_W-1:0]   w_raddr    [N_RD];
    logic [N_RD-1:0]     w_rin_range;

    generate
        for (genvar k = 0; k < N_WR; k++) begin : g_wr
            assign w_waddr[k]     = address_write[k*ADDR_W +: ADDR_W];
            assign w_wdata[k]     = data_write[k*DATA_W +: DATA_W];
            assign w_win_range[k] = ({1'b0, w_waddr[k]} < c_DEPTH);
        end
    endgenerate

    // Reads stay at zero while the sweep runs and for out-of-range addresses.
    generate
        for (genvar r = 0; r < N_RD; r++) begin : g_rd
            assign w_raddr[r]     = address_read[r*ADDR_W +: ADDR_W];
            assign w_rin_range[r] = ({1'b0, w_raddr[r]} < c_DEPTH);
            assign readed[r*DATA_W +: DATA_W] =
                (r_state == S_RUN && w_rin_range[r]) ? r_mem[w_raddr[r][c_IDX_W-1:0]] : '0;
        end
    endgenerate

    // A port commits only if no higher-numbered enabled port targets the same word.
    always_comb begin
        w_commit = '0;
        w_coll   = 1'b0;
        w_oob_wr = 1'b0;
        for (int k = 0; k < N_WR; k++) begin
            if (write[k]) begin
                if (w_win_range[k]) begin
                    w_commit[k] = 1'b1;
                end else begin
                    w_oob_wr = 1'b1;
                end
                for (int j = k + 1; j < N_WR; j++) begin
                    if (write[j] && (w_waddr[j] == w_waddr[k])) begin
                        w_commit[k] = 1'b0;
                        w_coll      = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == S_INIT && r_init_ptr == c_LAST) begin
            w_state_next = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_ptr <= '0;
        end else if (r_state == S_INIT) begin
            r_init_ptr <= r_init_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || r_state == S_INIT) begin
            r_collision <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            r_collision <= w_coll;
            r_oob       <= w_oob_wr | ~(&w_rin_range);
        end
    end

    // Array itself is never reset; only the sweep establishes contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_INIT) begin
                r_mem[r_init_ptr] <= INIT_VAL;
            end else begin
                for (int k = 0; k < N_WR; k++) begin
                    if (w_commit[k]) begin
                        r_mem[w_waddr[k][c_IDX_W-1:0]] <= w_wdata[k];
                    end
                end
            end
        end
    end

    assign init_busy = (r_state == S_INIT);
    assign collision = r_collision;
    assign oob       = r_oob;

endmodule
`default_nettype wire

// File: doc/mem_multiport_init.md
# mem_multiport_init

Parametrised multi-port word memory for the MSI coherence model: N_RD combinational read ports and N_WR write ports on one clock. Replaces the fixed 512x32, 2-read/4-write memory. Adds a synchronous reset, a hardware clear sequence that sweeps every entry, and deterministic same-address write arbitration with a collision flag. Sits behind the bus/cache controllers as backing store.

## Interface
- DATA_W, 32, word width in bits
- ADDR_W, 9, address width
- DEPTH, 512, number of words (must be <= 2**ADDR_W)
- N_RD, 2, number of read ports (>= 1)
- N_WR, 4, number of write ports (>= 1)
- INIT_VAL, 0, value written to every entry by the clear sequence
- clk  in  1  sole clock, all state updates on posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- write  in  N_WR  per-port write enable, bit k = port k
- address_write  in  N_WR*ADDR_W  port k at [k*ADDR_W +: ADDR_W]
- data_write  in  N_WR*DATA_W  port k at [k*DATA_W +: DATA_W]
- address_read  in  N_RD*ADDR_W  port r at [r*ADDR_W +: ADDR_W]
- readed  out  N_RD*DATA_W  read data, port r at [r*DATA_W +: DATA_W]
- init_busy  out  1  clear sequence in progress; writes ignored
- collision  out  1  registered pulse: previous cycle had >=2 enabled writes to one address
- oob  out  1  registered pulse: previous cycle had an enabled write or a read with address >= DEPTH

## Operation
- States: INIT, RUN. Reset value: INIT, init_ptr=0, init_busy=1, collision=0, oob=0.
- reset high at a posedge: state<=INIT, init_ptr<=0, collision<=0, oob<=0; no array write that edge. Applies from any state, including mid-INIT (sweep restarts at 0).
- INIT, reset low: mem[init_ptr]<=INIT_VAL; init_ptr<=init_ptr+1; on edge clearing DEPTH-1, state<=RUN, init_busy<=0.
- INIT: all user writes ignored; readed forced to 0 on all ports; collision and oob held 0.
- RUN: for each address, winning write = highest-numbered enabled port k targeting it; lower ports to the same address are dropped. Ports to distinct addresses all commit on the same edge.
- RUN: write with address >= DEPTH is dropped (no array effect, no wrap); sets oob.
- Reads combinational: readed[r] = mem[address_read[r]] if address < DEPTH, else 0 (and oob set next edge while in RUN).
- Read during write to same address: readed shows old value until the edge, new value after.
- No power-on contents other than through INIT; simulation-only $display dumps are not part of the block.

## Timing
- Write latency: data visible on readed combinationally immediately after the committing posedge.
- Read latency: 0 cycles (combinational from address_read and array).
- Clear: first edge with reset low clears entry 0; init_busy falls on the edge clearing DEPTH-1, i.e. high for exactly DEPTH cycles after reset release. First accepted write is on edge DEPTH+1 after release.
- collision, oob: asserted for one cycle after the offending edge; re-evaluated every cycle (back-to-back violations keep them high).
- Simultaneous reset and writes: reset wins, writes dropped.

## Test plan
- DEPTH=16: pulse reset 1 cycle, release -> init_busy high 16 cycles then low; all 16 entries read INIT_VAL (set 32'hA5A5A5A5); write at cycle 15 after release ignored, at cycle 17 accepted.
- RUN: ports 0..3 write 0x11,0x22,0x33,0x44 to addrs 1,2,3,4 same edge -> reads of 1..4 return those values next cycle; collision=0.
- RUN: ports 0,2,3 write 0xAA,0xBB,0xCC to addr 5 -> mem[5]=0xCC; collision=1 for one cycle only.
- RUN, DEPTH=16: port 1 writes 0xDEAD to addr 20 -> no entry changes, oob=1 one cycle; read addr 20 -> readed=0.
- Read port 0 addr 7 while port 3 writes 0x77 to addr 7 -> readed old value before edge, 0x77 after.
- Reset asserted at cycle 8 of INIT, released -> sweep restarts at 0, init_busy high 16 more cycles; prior RUN contents overwritten to INIT_VAL.
